// File: rtl/execute_cc.sv
// Execute stage for a single-cycle Y86-64 core: ALU result, branch/cmov condition
// and the architectural condition-code register (ZF, SF, OF).
module execute_cc #(
    parameter int W         = 64,
    parameter int STACK_INC = 8
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic [3:0]   icode,
    input  logic [3:0]   ifun,
    input  logic [W-1:0] valA,
    input  logic [W-1:0] valB,
    input  logic [W-1:0] valC,
    input  logic         INS,
    input  logic         ADR,
    input  logic         HLT,
    output logic [W-1:0] valE,
    output logic         Cnd,
    output logic         ZF,
    output logic         SF,
    output logic         OF
);

    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic [W-1:0] STACK_OFF = W'(STACK_INC);

    logic zf_q, zf_d;
    logic sf_q, sf_d;
    logic of_q, of_d;
    logic cc_wr;
    logic sign_a, sign_b, sign_e;
    logic lt;

    always_comb begin
        valE = '0;
        unique case (icode)
            I_CMOV:           valE = valA;
            I_IRMOV:          valE = valC;
            I_RMMOV, I_MRMOV: valE = valB + valC;
            I_OPQ: begin
                case (ifun)
                    4'h0:    valE = valB + valA;
                    4'h1:    valE = valB - valA;
                    4'h2:    valE = valB & valA;
                    4'h3:    valE = valB ^ valA;
                    default: valE = '0;
                endcase
            end
            I_CALL, I_PUSH:   valE = valB - STACK_OFF;
            I_RET, I_POP:     valE = valB + STACK_OFF;
            default:          valE = '0;
        endcase
    end

    // Condition uses the flags as they stand before this instruction's own CC write.
    always_comb begin
        lt  = sf_q ^ of_q;
        Cnd = 1'b0;
        if (icode == I_CMOV || icode == I_JXX) begin
            case (ifun)
                4'h0:    Cnd = 1'b1;
                4'h1:    Cnd = lt | zf_q;
                4'h2:    Cnd = lt;
                4'h3:    Cnd = zf_q;
                4'h4:    Cnd = ~zf_q;
                4'h5:    Cnd = ~lt;
                4'h6:    Cnd = ~lt & ~zf_q;
                default: Cnd = 1'b0;
            endcase
        end
    end

    always_comb begin
        sign_a = valA[W-1];
        sign_b = valB[W-1];
        sign_e = valE[W-1];
        cc_wr  = (icode == I_OPQ) && (ifun <= 4'h3) && !INS && !ADR && !HLT;
        zf_d   = zf_q;
        sf_d   = sf_q;
        of_d   = of_q;
        if (cc_wr) begin
            zf_d = (valE == '0);
            sf_d = sign_e;
            case (ifun)
                4'h0:    of_d = (sign_a == sign_b) && (sign_e != sign_b);
                4'h1:    of_d = (sign_a != sign_b) && (sign_e != sign_b);
                default: of_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            zf_q <= 1'b1;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else begin
            zf_q <= zf_d;
            sf_q <= sf_d;
            of_q <= of_d;
        end
    end

    assign ZF = zf_q;
    assign SF = sf_q;
    assign OF = of_q;

endmodule

// File: tb/tb_execute_cc.sv
// Self-checking bench for execute_cc: directed scenarios plus a randomized run
// against a signed-arithmetic reference model of the flags.
module tb_execute_cc;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [3:0]  icode, ifun;
    logic [63:0] valA, valB, valC;
    logic        INS, ADR, HLT;
    logic [63:0] valE;
    logic        Cnd, ZF, SF, OF;

    int total = 0;
    int bad   = 0;

    // model of the architectural flags
    logic m_zf, m_sf, m_of;

    execute_cc #(.W(64), .STACK_INC(8)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .icode(icode), .ifun(ifun),
        .valA(valA), .valB(valB), .valC(valC),
        .INS(INS), .ADR(ADR), .HLT(HLT),
        .valE(valE), .Cnd(Cnd), .ZF(ZF), .SF(SF), .OF(OF)
    );

    always #5 Clk = ~Clk;

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         input logic ins, input logic adr, input logic hlt);
        icode = ic; ifun = fn; valA = a; valB = b; valC = c;
        INS = ins; ADR = adr; HLT = hlt;
        #1;
    endtask

    // Advance one clock edge, leaving time 1 unit after it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [63:0] model_vale(input logic [3:0] ic, input logic [3:0] fn,
                                               input logic [63:0] a, input logic [63:0] b,
                                               input logic [63:0] c);
        case (ic)
            4'h2: return a;
            4'h3: return c;
            4'h4, 4'h5: return b + c;
            4'h6: begin
                if (fn == 0) return b + a;
                if (fn == 1) return b - a;
                if (fn == 2) return b & a;
                if (fn == 3) return b ^ a;
                return 64'd0;
            end
            4'h8, 4'hA: return b - 64'd8;
            4'h9, 4'hB: return b + 64'd8;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic model_cnd(input logic [3:0] ic, input logic [3:0] fn,
                                       input logic z, input logic s, input logic o);
        logic less;
        less = s ^ o;
        if (ic != 4'h2 && ic != 4'h7) return 1'b0;
        case (fn)
            0: return 1'b1;
            1: return less | z;
            2: return less;
            3: return z;
            4: return !z;
            5: return !less;
            6: return !less && !z;
            default: return 1'b0;
        endcase
    endfunction

    // Overflow judged on the true signed result: it overflows if it leaves the 64-bit range.
    function automatic logic model_of(input logic [3:0] fn, input logic [63:0] a, input logic [63:0] b);
        logic signed [65:0] sa, sb, r;
        sa = 66'(signed'(a));
        sb = 66'(signed'(b));
        if (fn == 0) r = sb + sa;
        else if (fn == 1) r = sb - sa;
        else return 1'b0;
        return (r > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (r < -66'sh0_8000_0000_0000_0000);
    endfunction

    task automatic check_flags(input string name, input logic z, input logic s, input logic o);
        total++;
        if ({ZF, SF, OF} !== {z, s, o}) begin
            bad++;
            $display("FAIL %s: got ZF/SF/OF=%b%b%b want %b%b%b", name, ZF, SF, OF, z, s, o);
        end
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 0, 0, 0);
        tick(); tick();
        check_flags("reset_flags", 1'b1, 1'b0, 1'b0);
        Rst_n = 1'b1;
        drive(4'h2, 4'h1, 64'd0, 64'd0, 64'd0, 0, 0, 0);
        total++;
        if (Cnd !== 1'b1) begin bad++; $display("FAIL reset_cmovle: got %b want 1", Cnd); end
        drive(4'h2, 4'h6, 64'd0, 64'd0, 64'd0, 0, 0, 0);
        total++;
        if (Cnd !== 1'b0) begin bad++; $display("FAIL reset_cmovg: got %b want 0", Cnd); end
    endtask

    task automatic test_sub_zero();
        drive(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 0, 0, 0);
        total++;
        if (valE !== 64'd0) begin bad++; $display("FAIL sub_vale: got %h want 0", valE); end
        tick();
        drive(4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 0, 0, 0);
        check_flags("sub_flags", 1'b1, 1'b0, 1'b0);
        total++;
        if (Cnd !== 1'b1) begin bad++; $display("FAIL sub_je: got %b want 1", Cnd); end
    endtask

    task automatic test_add_overflow();
        drive(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 0, 0, 0);
        total++;
        if (valE !== 64'h8000_0000_0000_0000) begin
            bad++; $display("FAIL add_vale: got %h want 8000000000000000", valE);
        end
        tick();
        drive(4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 0, 0, 0);
        check_flags("add_flags", 1'b0, 1'b1, 1'b1);
        total++;
        if (Cnd !== 1'b0) begin bad++; $display("FAIL add_jl: got %b want 0", Cnd); end
        drive(4'h7, 4'h4, 64'd0, 64'd0, 64'd0, 0, 0, 0);
        total++;
        if (Cnd !== 1'b1) begin bad++; $display("FAIL add_jne: got %b want 1", Cnd); end
    endtask

    task automatic test_stack();
        drive(4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 0, 0, 0);
        total++;
        if (valE !== 64'hF8) begin bad++; $display("FAIL push_vale: got %h want f8", valE); end
        tick();
        drive(4'h9, 4'h0, 64'd0, 64'h100, 64'd0, 0, 0, 0);
        total++;
        if (valE !== 64'h108) begin bad++; $display("FAIL ret_vale: got %h want 108", valE); end
        tick();
        drive(4'h4, 4'h0, 64'd0, 64'h10, -64'sd8, 0, 0, 0);
        total++;
        if (valE !== 64'h8) begin bad++; $display("FAIL rmmov_vale: got %h want 8", valE); end
        tick();
        drive(4'hA, 4'h0, 64'd0, 64'd0, 64'd0, 0, 0, 0);
        total++;
        if (valE !== 64'hFFFF_FFFF_FFFF_FFF8) begin
            bad++; $display("FAIL push_wrap: got %h want fffffffffffffff8", valE);
        end
        tick();
        check_flags("stack_flags", 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_status_suppress();
        for (int k = 0; k < 3; k++) begin
            drive(4'h6, 4'h3, 64'hAA, 64'hAA, 64'd0, k == 0, k == 2, k == 1);
            total++;
            if (valE !== 64'd0) begin bad++; $display("FAIL status_vale[%0d]: got %h want 0", k, valE); end
            tick();
            check_flags($sformatf("status_hold[%0d]", k), 1'b0, 1'b1, 1'b1);
        end
    endtask

    task automatic test_reset_wins();
        Rst_n = 1'b0;
        drive(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 0, 0, 0);
        tick();
        Rst_n = 1'b1;
        check_flags("reset_wins", 1'b1, 1'b0, 1'b0);
        drive(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 0, 0, 0);
        tick();
        check_flags("add_1_1", 1'b0, 1'b0, 1'b0);
        drive(4'h6, 4'h3, 64'd3, 64'd3, 64'd0, 0, 0, 0);
        tick();
        check_flags("xor_zero", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [3:0]  ic, fn;
        logic [63:0] a, b, c, e;
        logic        ins, adr, hlt, rst;
        int          pick;
        m_zf = ZF; m_sf = SF; m_of = OF;
        for (int n = 0; n < 300; n++) begin
            pick = $urandom_range(0, 9);
            ic = (pick < 4) ? 4'h6 : (pick < 6) ? 4'h7 : (pick < 7) ? 4'h2 : 4'($urandom_range(0, 15));
            fn = 4'($urandom_range(0, 8));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            c = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) a = {a[63], 63'($urandom_range(0, 3))};
            if ($urandom_range(0, 4) == 0) b = a;
            ins = ($urandom_range(0, 9) == 0);
            adr = ($urandom_range(0, 9) == 0);
            hlt = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 19) != 0);
            Rst_n = rst;
            drive(ic, fn, a, b, c, ins, adr, hlt);
            e = model_vale(ic, fn, a, b, c);
            total++;
            if (valE !== e) begin bad++; $display("FAIL rnd_vale[%0d]: got %h want %h", n, valE, e); end
            total++;
            if (Cnd !== model_cnd(ic, fn, m_zf, m_sf, m_of)) begin
                bad++; $display("FAIL rnd_cnd[%0d]: got %b want %b", n, Cnd, model_cnd(ic, fn, m_zf, m_sf, m_of));
            end
            tick();
            if (!rst) begin
                m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
            end else if (ic == 4'h6 && fn <= 4'h3 && !ins && !adr && !hlt) begin
                m_zf = (e == 64'd0);
                m_sf = signed'(e) < 0;
                m_of = model_of(fn, a, b);
            end
            check_flags($sformatf("rnd_flags[%0d]", n), m_zf, m_sf, m_of);
        end
        Rst_n = 1'b1;
    endtask

    initial begin
        Rst_n = 1'b0;
        drive(4'h0, 4'h0, 64'd0, 64'd0, 64'd0, 0, 0, 0);
        test_reset();
        test_sub_zero();
        test_add_overflow();
        test_stack();
        test_status_suppress();
        test_reset_wins();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
